// File: rtl/dense_param_loader.sv
// Dense layer parameter loader.
// Receives a valid/ready word stream and stores it in row-major order into a
// weight matrix, then a bias vector. The stored parameters drive a dense layer
// directly. params_valid marks a complete set of parameters. busy marks a load
// that is still in progress.
//
// Handshake: a word moves on a rising edge only when in_valid and in_ready are
// both 1. in_ready depends only on state; it is high in LOAD_W and LOAD_B and
// never looks at in_valid. A start pulse takes priority over a word on the same
// edge; that word is discarded.
module dense_param_loader #(
  parameter int WIDTH       = 17,
  parameter int INPUT_SIZE  = 32,
  parameter int OUTPUT_SIZE = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] weights [0:INPUT_SIZE-1][0:OUTPUT_SIZE-1],
  output logic signed [WIDTH-1:0] bias [0:OUTPUT_SIZE-1],
  output logic                    params_valid,
  output logic                    busy,
  output logic [1:0]              dbg_state
);

  localparam int RW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int CW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    LOAD_B = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic          xfer;
  logic          col_last;
  logic          last_w;
  logic          last_b;

  assign in_ready  = (state_q == LOAD_W) || (state_q == LOAD_B);
  assign xfer      = in_valid && in_ready && !start;
  assign col_last  = (col_q == CW'(OUTPUT_SIZE - 1));
  assign last_w    = (state_q == LOAD_W) && col_last && (row_q == RW'(INPUT_SIZE - 1));
  assign last_b    = (state_q == LOAD_B) && col_last;
  assign dbg_state = state_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: start always (re)enters LOAD_W, otherwise advance on the final beat of each phase.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = LOAD_W;
      LOAD_W: begin
        if (start)               state_d = LOAD_W;
        else if (xfer && last_w) state_d = LOAD_B;
      end
      LOAD_B: begin
        if (start)               state_d = LOAD_W;
        else if (xfer && last_b) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Row/column counters; the column counter is reused as the bias index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_q <= '0;
      col_q <= '0;
    end else if (start) begin
      row_q <= '0;
      col_q <= '0;
    end else if (xfer) begin
      if (state_q == LOAD_W) begin
        if (last_w) begin
          row_q <= '0;
          col_q <= '0;
        end else if (col_last) begin
          row_q <= row_q + RW'(1);
          col_q <= '0;
        end else begin
          col_q <= col_q + CW'(1);
        end
      end else begin
        col_q <= last_b ? '0 : col_q + CW'(1);
      end
    end
  end

  // Parameter storage: written only on an accepted word, otherwise holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < INPUT_SIZE; i++)
        for (int j = 0; j < OUTPUT_SIZE; j++)
          weights[i][j] <= '0;
      for (int j = 0; j < OUTPUT_SIZE; j++)
        bias[j] <= '0;
    end else if (xfer) begin
      if (state_q == LOAD_W) weights[row_q][col_q] <= in_data;
      else                   bias[col_q]           <= in_data;
    end
  end

  // Status flags registered from next state so they track the state exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      params_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      params_valid <= (state_d == DONE);
      busy         <= (state_d == LOAD_W) || (state_d == LOAD_B);
    end
  end

endmodule

// File: tb/tb_dense_param_loader.sv
// Testbench for dense_param_loader with WIDTH=8, INPUT_SIZE=3, OUTPUT_SIZE=2.
module tb_dense_param_loader;

  localparam int W  = 8;
  localparam int IS = 3;
  localparam int OS = 2;

  // ---------------- clock / reset / DUT ----------------
  logic                clk;
  logic                reset;
  logic                start;
  logic                in_valid;
  logic signed [W-1:0] in_data;
  logic                in_ready;
  logic signed [W-1:0] weights [0:IS-1][0:OS-1];
  logic signed [W-1:0] bias [0:OS-1];
  logic                params_valid;
  logic                busy;
  logic [1:0]          dbg_state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  dense_param_loader #(.WIDTH(W), .INPUT_SIZE(IS), .OUTPUT_SIZE(OS)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .weights     (weights),
    .bias        (bias),
    .params_valid(params_valid),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  logic signed [W-1:0] exp_w  [0:IS-1][0:OS-1];
  logic signed [W-1:0] exp_b  [0:OS-1];
  logic signed [W-1:0] snap_w [0:IS-1][0:OS-1];
  logic signed [W-1:0] snap_b [0:OS-1];

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic set_exp(input int a0, input int a1, input int a2, input int a3,
                         input int a4, input int a5, input int a6, input int a7);
    exp_w[0][0] = W'(a0); exp_w[0][1] = W'(a1);
    exp_w[1][0] = W'(a2); exp_w[1][1] = W'(a3);
    exp_w[2][0] = W'(a4); exp_w[2][1] = W'(a5);
    exp_b[0]    = W'(a6); exp_b[1]    = W'(a7);
  endtask

  task automatic check_arrays(input string name);
    for (int i = 0; i < IS; i++)
      for (int j = 0; j < OS; j++)
        chk($sformatf("%s_w[%0d][%0d]", name, i, j), weights[i][j], exp_w[i][j]);
    for (int j = 0; j < OS; j++)
      chk($sformatf("%s_b[%0d]", name, j), bias[j], exp_b[j]);
  endtask

  task automatic take_snap();
    snap_w = weights;
    snap_b = bias;
  endtask

  task automatic check_snap(input string name);
    for (int i = 0; i < IS; i++)
      for (int j = 0; j < OS; j++)
        chk($sformatf("%s_hold_w[%0d][%0d]", name, i, j), weights[i][j], snap_w[i][j]);
    for (int j = 0; j < OS; j++)
      chk($sformatf("%s_hold_b[%0d]", name, j), bias[j], snap_b[j]);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic                st;
    logic                vld;
    logic signed [W-1:0] d;
    logic                exp_rdy;   // in_ready before the edge
    logic                exp_busy;  // after the edge
    logic                exp_pv;    // after the edge
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic st, input logic vld, input int d,
                              input logic rdy, input logic bsy, input logic pv);
    vec_t v;
    v.st = st; v.vld = vld; v.d = W'(d);
    v.exp_rdy = rdy; v.exp_busy = bsy; v.exp_pv = pv;
    vq.push_back(v);
  endfunction

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; leaves the bench #1 after the next one.
  task automatic apply(input vec_t v, input string name);
    start    = v.st;
    in_valid = v.vld;
    in_data  = v.d;
    #1;
    chk({name, "_ready"}, in_ready, v.exp_rdy);
    take_snap();
    @(posedge clk);
    #1;
    chk({name, "_busy"}, busy, v.exp_busy);
    chk({name, "_pv"}, params_valid, v.exp_pv);
    if (!v.vld) check_snap(name);
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic run_table(input string name, input int lo, input int hi);
    for (int k = lo; k < hi; k++)
      apply(vq[k], $sformatf("%s_v%0d", name, k));
  endtask

  task automatic idle_push(input string name, input logic exp_pv);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = 8'sd33;
      #1;
      chk($sformatf("%s_ready_c%0d", name, c), in_ready, 1'b0);
      @(posedge clk);
      #1;
      chk($sformatf("%s_busy_c%0d", name, c), busy, 1'b0);
      chk($sformatf("%s_pv_c%0d", name, c), params_valid, exp_pv);
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // ---------------- test ----------------
  int s_a [8] = '{1, 2, 3, 4, 5, 6, -7, -8};
  int s_r [8] = '{-128, 127, 0, -1, 1, -2, 2, -3};

  initial begin
    int n50;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #1 reset = 1'b0;
    #1;
    // Reset state
    set_exp(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pv", params_valid, 1'b0);
    chk("rst_state", dbg_state, 2'd0);
    check_arrays("rst");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    // Words in IDLE are ignored
    idle_push("idle33", 1'b0);
    check_arrays("idle33");

    // Back-to-back load
    vq.delete();
    add(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) add(0, 1, s_a[i], 1, i < 7, i == 7);
    add(0, 0, 0, 0, 0, 1);
    run_table("b2b", 0, vq.size());
    set_exp(1, 2, 3, 4, 5, 6, -7, -8);
    check_arrays("b2b");

    // Valid toggling 1,0,1,0 with junk data in gaps; reload from DONE
    vq.delete();
    add(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      add(0, 1, s_a[i], 1, i < 7, i == 7);
      add(0, 0, 99, i < 7, i < 7, i == 7);
    end
    run_table("gap", 0, vq.size());
    check_arrays("gap");

    // Restart mid-load with a word presented on the restart edge
    vq.delete();
    add(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 9, 1, 1, 0);
    add(1, 1, 50, 1, 1, 0);
    for (int i = 0; i < 8; i++) add(0, 1, 10 + i, 1, i < 7, i == 7);
    run_table("rst_mid", 0, 5);
    set_exp(9, 9, 9, 4, 5, 6, -7, -8);
    check_arrays("restart_keep");
    run_table("rst_mid", 5, vq.size());
    set_exp(10, 11, 12, 13, 14, 15, 16, 17);
    check_arrays("restart");
    n50 = 0;
    for (int i = 0; i < IS; i++)
      for (int j = 0; j < OS; j++)
        if (weights[i][j] == 8'sd50) n50++;
    for (int j = 0; j < OS; j++)
      if (bias[j] == 8'sd50) n50++;
    chk("no_50", n50, 0);

    // Words in DONE are ignored
    idle_push("done33", 1'b1);
    check_arrays("done33");

    // Reload with extreme values; pv drops on the start edge
    vq.delete();
    add(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) add(0, 1, s_r[i], 1, i < 7, i == 7);
    run_table("extreme", 0, vq.size());
    set_exp(-128, 127, 0, -1, 1, -2, 2, -3);
    check_arrays("extreme");

    // Asynchronous reset after beat 4, then words without start
    vq.delete();
    add(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 20 + i, 1, 1, 0);
    run_table("areset", 0, vq.size());
    #2 reset = 1'b0;
    #1;
    set_exp(0, 0, 0, 0, 0, 0, 0, 0);
    chk("areset_ready", in_ready, 1'b0);
    chk("areset_busy", busy, 1'b0);
    chk("areset_pv", params_valid, 1'b0);
    chk("areset_state", dbg_state, 2'd0);
    check_arrays("areset");
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    idle_push("post_rst", 1'b0);
    check_arrays("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dense_param_loader.md
DENSE_PARAM_LOADER -- requirements
Module: dense_param_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 17: fixed-point word width.
REQ-002 SHALL have parameter INPUT_SIZE, default 32: dense layer input count, which is the weight row count.
REQ-003 SHALL have parameter OUTPUT_SIZE, default 32: dense layer output count, which is the weight column and bias count.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: one-cycle pulse that begins or restarts a parameter load.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data holds a valid word.
REQ-008 SHALL have port in_data, input, signed WIDTH bits: stream word.
REQ-009 SHALL have port in_ready, output, 1 bit: loader accepts a word this cycle.
REQ-010 SHALL have port weights, output, signed WIDTH bits, array [0:INPUT_SIZE-1][0:OUTPUT_SIZE-1]: drives the dense layer weight input.
REQ-011 SHALL have port bias, output, signed WIDTH bits, array [0:OUTPUT_SIZE-1]: drives the dense layer bias input.
REQ-012 SHALL have port params_valid, output, 1 bit: a complete parameter set is loaded.
REQ-013 SHALL have port busy, output, 1 bit: a load is in progress.

Function
REQ-014 SHALL implement the states IDLE, LOAD_W, LOAD_B and DONE.
REQ-015 SHALL transfer a word only on a rising edge where in_valid and in_ready are both 1.
REQ-016 SHALL drive in_ready combinationally from state: 1 in LOAD_W and LOAD_B, 0 otherwise; in_ready SHALL NOT depend on in_valid.
REQ-017 SHALL accept weights in row-major order: beat k writes weights[k / OUTPUT_SIZE][k % OUTPUT_SIZE], for k = 0 .. INPUT_SIZE*OUTPUT_SIZE-1.
REQ-018 SHALL accept bias after the last weight: bias beat j writes bias[j], for j = 0 .. OUTPUT_SIZE-1.
REQ-019 SHALL use separate row and column counters, or one beat counter, wide enough for INPUT_SIZE*OUTPUT_SIZE without wrap.
REQ-020 SHALL make these state transitions:
- IDLE or DONE, start=1 -> LOAD_W; counters cleared; params_valid cleared on the same edge.
- LOAD_W, transfer of the last weight -> LOAD_B; bias counter cleared.
- LOAD_B, transfer of the last bias -> DONE.
REQ-021 SHALL make params_valid and busy registered outputs: params_valid=1 exactly while in DONE, busy=1 exactly while in LOAD_W or LOAD_B.
REQ-022 SHALL assert params_valid on the first rising edge after the edge that transfers the last bias word, i.e. it is visible in the cycle following the final beat.
REQ-023 SHALL treat start=1 while in LOAD_W or LOAD_B as a restart to LOAD_W with counters at 0; any word presented on that edge SHALL be discarded; previously written entries SHALL remain until overwritten.
REQ-024 SHALL give start priority over a same-cycle transfer.
REQ-025 SHALL ignore in_valid and in_data in IDLE and DONE; weights and bias SHALL hold their values.
REQ-026 SHALL change no weights or bias entry when in_valid=0 or in_ready=0, including during stalls of any length; counters SHALL hold.
REQ-027 SHALL store words unmodified: no rounding, saturation or sign change, full WIDTH bits.
REQ-028 SHALL present parameter outputs directly from storage registers, with no combinational path from in_data.

Reset
REQ-029 SHALL, while reset=0, asynchronously force: state IDLE, all counters 0, every weights and bias entry 0, params_valid=0, busy=0, in_ready=0.
REQ-030 SHALL, on reset assertion mid-load, abandon the load immediately; the first load after reset deasserts SHALL require a new start pulse.
REQ-031 SHALL behave identically to IDLE on the first clock edge after reset deasserts.

Verification
Verification parameters: WIDTH=8, INPUT_SIZE=3, OUTPUT_SIZE=2; a full load is 8 beats.
REQ-032 SHALL pass this scenario: start, then 8 back-to-back beats of 1,2,3,4,5,6,-7,-8 -> weights = {{1,2},{3,4},{5,6}}, bias = {-7,-8}; params_valid=1 one cycle after beat 8; busy=0.
REQ-033 SHALL pass this scenario: the same stream with in_valid toggled 1,0,1,0 -> identical final arrays; params_valid rises only after the 8th accepted beat; no entry changes in gap cycles.
REQ-034 SHALL pass this scenario: start, 3 beats 9,9,9, start with in_valid=1 and in_data=50, then 8 beats 10..17 -> weights = {{10,11},{12,13},{14,15}}, bias = {16,17}; value 50 never appears.
REQ-035 SHALL pass this scenario: in_valid=1 with in_data=33 in IDLE and in DONE for 5 cycles each -> in_ready=0 and arrays unchanged.
REQ-036 SHALL pass this scenario: reset=0 asserted asynchronously after beat 4 -> all outputs 0 before the next clock edge; after release, words without start are not accepted.
REQ-037 SHALL pass this scenario: reload with the stream -128,127,0,-1,1,-2,2,-3 from DONE -> params_valid drops on the start edge; the new values are stored exactly, including the extremes -128 and 127.
